// File: rtl/frame_streamer.sv
// Replays a stored frame from pixel memory as a camera-style VSYNC / HREF / PXCLK / D[7:0] stream.
// Define TEST_PATTERN_EN to add pattern_sel, which swaps the memory path for an XOR test pattern.
module frame_streamer #(
   parameter int unsigned ADDR_W      = 23,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned BPP         = 2,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10
) (
   input  logic              clock,
   input  logic              reset,
`ifdef TEST_PATTERN_EN
   input  logic              pattern_sel,
`endif
   input  logic              start,
   input  logic              continuous,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              PXCLK,
   output logic              VSYNC,
   output logic              HSYNC,
   output logic [7:0]        D,
   output logic              busy,
   output logic              done
);

   localparam int unsigned ACT_SLOTS  = H_ACTIVE * BPP;
   localparam int unsigned LINE_SLOTS = ACT_SLOTS + H_BLANK;
   localparam int unsigned V_MAX_A    = (V_ACTIVE > VSYNC_LINES) ? V_ACTIVE : VSYNC_LINES;
   localparam int unsigned V_MAX_B    = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
   localparam int unsigned V_MAX      = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int unsigned SW         = $clog2(LINE_SLOTS);
   localparam int unsigned LW         = $clog2(V_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_VS, ST_VBACK, ST_ACTIVE, ST_HBL, ST_VFRONT, ST_DONE
   } state_e;

   state_e            state_q;
   logic              ph_q;
   logic [SW-1:0]     slot_q;
   logic [LW-1:0]     line_q;
   logic [ADDR_W-1:0] rd_idx_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_rd_q;
   logic              vsync_q;
   logic              hsync_q;
   logic [7:0]        d_q;
   logic              busy_q;
   logic              done_q;
   logic              start_pend_q;

   logic              slot_last_c;
   logic              line_last_c;
   logic              nxt_act_c;
   logic              mem_path_c;
`ifdef TEST_PATTERN_EN
   logic [SW-1:0]     nxt_byte_c;
   logic [LW-1:0]     nxt_line_c;
   logic [7:0]        pat_c;
`endif

   // Position of the current slot and whether the following slot carries an active byte
   always_comb begin
      slot_last_c = (slot_q == SW'(LINE_SLOTS - 1));
      line_last_c = 1'b0;
      nxt_act_c   = 1'b0;
`ifdef TEST_PATTERN_EN
      nxt_byte_c  = '0;
      nxt_line_c  = '0;
`endif
      case (state_q)
         ST_VS:     line_last_c = (line_q == LW'(VSYNC_LINES - 1));
         ST_VBACK: begin
            line_last_c = (line_q == LW'(V_BACK - 1));
            nxt_act_c   = slot_last_c && line_last_c;
         end
         ST_ACTIVE: begin
            line_last_c = (line_q == LW'(V_ACTIVE - 1));
            nxt_act_c   = (slot_q != SW'(ACT_SLOTS - 1));
`ifdef TEST_PATTERN_EN
            nxt_byte_c  = slot_q + 1'b1;
            nxt_line_c  = line_q;
`endif
         end
         ST_HBL: begin
            line_last_c = (line_q == LW'(V_ACTIVE - 1));
            nxt_act_c   = slot_last_c && !line_last_c;
`ifdef TEST_PATTERN_EN
            nxt_line_c  = line_q + 1'b1;
`endif
         end
         ST_VFRONT: line_last_c = (line_q == LW'(V_FRONT - 1));
         default:   line_last_c = 1'b0;
      endcase
   end

`ifdef TEST_PATTERN_EN
   assign pat_c      = 8'(nxt_byte_c) ^ 8'(nxt_line_c);
   assign mem_path_c = ~pattern_sel;
`else
   assign mem_path_c = 1'b1;
`endif

   // Phase 0->1 edge launches the read; phase 1->0 edge loads D and advances the slot FSM
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ph_q         <= 1'b0;
         slot_q       <= '0;
         line_q       <= '0;
         rd_idx_q     <= '0;
         mem_addr_q   <= '0;
         mem_rd_q     <= 1'b0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         d_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         start_pend_q <= 1'b0;
      end else begin
         ph_q <= ~ph_q;
         if (!ph_q) begin
            if (state_q == ST_IDLE && start) start_pend_q <= 1'b1;
            if (nxt_act_c && mem_path_c) begin
               mem_rd_q   <= 1'b1;
               mem_addr_q <= rd_idx_q;
               rd_idx_q   <= rd_idx_q + 1'b1;
            end
         end else begin
            mem_rd_q <= 1'b0;
            if (mem_rd_q) d_q <= mem_rdata;
`ifdef TEST_PATTERN_EN
            else if (pattern_sel && nxt_act_c) d_q <= pat_c;
`endif
            else d_q <= '0;

            if (state_q != ST_IDLE && state_q != ST_DONE) begin
               slot_q <= slot_last_c ? '0 : slot_q + 1'b1;
               if (slot_last_c) line_q <= line_last_c ? '0 : line_q + 1'b1;
            end

            case (state_q)
               ST_IDLE: begin
                  if (start || start_pend_q) begin
                     state_q      <= ST_VS;
                     vsync_q      <= 1'b1;
                     busy_q       <= 1'b1;
                     slot_q       <= '0;
                     line_q       <= '0;
                     rd_idx_q     <= '0;
                     mem_addr_q   <= '0;
                     start_pend_q <= 1'b0;
                  end
               end
               ST_VS: begin
                  if (slot_last_c && line_last_c) begin
                     state_q <= ST_VBACK;
                     vsync_q <= 1'b0;
                  end
               end
               ST_VBACK: begin
                  if (slot_last_c && line_last_c) begin
                     state_q <= ST_ACTIVE;
                     hsync_q <= 1'b1;
                  end
               end
               ST_ACTIVE: begin
                  if (slot_q == SW'(ACT_SLOTS - 1)) begin
                     state_q <= ST_HBL;
                     hsync_q <= 1'b0;
                  end
               end
               ST_HBL: begin
                  if (slot_last_c) begin
                     if (line_last_c) begin
                        state_q <= ST_VFRONT;
                     end else begin
                        state_q <= ST_ACTIVE;
                        hsync_q <= 1'b1;
                     end
                  end
               end
               ST_VFRONT: begin
                  if (slot_last_c && line_last_c) begin
                     if (continuous) begin
                        state_q    <= ST_VS;
                        vsync_q    <= 1'b1;
                        rd_idx_q   <= '0;
                        mem_addr_q <= '0;
                     end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end

         // DONE always lands on a phase-0 cycle and lasts exactly one clock
         if (state_q == ST_DONE) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
         end
      end
   end

   assign PXCLK    = ph_q;
   assign VSYNC    = vsync_q;
   assign HSYNC    = hsync_q;
   assign D        = d_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Bench for frame_streamer: table-driven frame runs checked against a per-slot frame model,
// plus hand-written sequences for back-to-back starts and mid-frame reset.
module tb_frame_streamer;

   localparam int unsigned ADDR_W = 12;
   localparam int HA = 4, VA = 3, BPPX = 2, HB = 2, VSL = 1, VB = 1, VF = 1;
   localparam int ACT        = HA * BPPX;
   localparam int LINE       = ACT + HB;
   localparam int NBYTES     = ACT * VA;
   localparam int FRAME_CLKS = 2 * LINE * (VSL + VB + VA + VF);

   typedef struct packed {
      logic       vs;
      logic       hs;
      logic [7:0] d;
   } slot_t;

   typedef struct {
      int n_frames;
      int delay;
      bit rand_mem;
      bit mid_start;
      bit pat;
      int exp_rd;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset, start, continuous;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_rdata;
   logic              PXCLK, VSYNC, HSYNC, busy, done;
   logic [7:0]        D;
`ifdef TEST_PATTERN_EN
   logic              pattern_sel = 1'b0;
`endif

   logic [7:0]  mem_arr [NBYTES];
   slot_t       obs_q [$];
   int          rd_q [$];
   int          n_chk = 0, n_pass = 0;
   int          done_cnt = 0, vs_rise = 0, hs_rise = 0;

   frame_streamer #(
      .ADDR_W(ADDR_W), .H_ACTIVE(HA), .V_ACTIVE(VA), .BPP(BPPX), .H_BLANK(HB),
      .VSYNC_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)
   ) dut (
      .clock(clk),
      .reset(reset),
`ifdef TEST_PATTERN_EN
      .pattern_sel(pattern_sel),
`endif
      .start(start),
      .continuous(continuous),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_rdata(mem_rdata),
      .PXCLK(PXCLK),
      .VSYNC(VSYNC),
      .HSYNC(HSYNC),
      .D(D),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_val(input int a);
      return (a >= 0 && a < NBYTES) ? mem_arr[a] : 8'hEE;
   endfunction

   // Data is only presented while the strobe is high, so a mistimed capture shows up as 0xEE
   always_comb begin
      mem_rdata = 8'hEE;
      if (mem_rd) mem_rdata = mem_val(int'(mem_addr));
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic fill_mem(input bit rnd);
      for (int i = 0; i < NBYTES; i++) mem_arr[i] = rnd ? 8'($urandom) : 8'(i);
   endtask

   // Monitor: one record per slot at PXCLK high, read strobes, and done/busy handshake
   logic       prev_rd = 1'b0, prev_done = 1'b0, prev_vs = 1'b0, prev_hs = 1'b0;
   int         prev_addr = 0;
   always @(negedge clk) begin
      slot_t s;
      if (reset) begin
         prev_rd = 1'b0; prev_done = 1'b0; prev_vs = 1'b0; prev_hs = 1'b0;
      end else begin
         if (prev_rd) chk("rd_to_d", 64'(D), 64'(mem_val(prev_addr)));
         if (prev_done) chk("busy_done_after_done", 64'({busy, done}), 64'(0));
         if (mem_rd) begin
            chk("rd_in_phase1", 64'(PXCLK), 64'(1));
            rd_q.push_back(int'(mem_addr));
         end
         if (done) begin
            done_cnt++;
            chk("busy_during_done", 64'(busy), 64'(1));
         end
         if (PXCLK && busy) begin
            s.vs = VSYNC; s.hs = HSYNC; s.d = D;
            obs_q.push_back(s);
         end
         if (VSYNC && !prev_vs) vs_rise++;
         if (HSYNC && !prev_hs) hs_rise++;
         prev_rd = mem_rd; prev_addr = int'(mem_addr); prev_done = done;
         prev_vs = VSYNC;  prev_hs = HSYNC;
      end
   end

   // Reference: the slot stream of n frames built straight from the frame layout
   task automatic build_exp(input int n, input bit pat, output slot_t q[$]);
      slot_t s;
      q.delete();
      for (int f = 0; f < n; f++) begin
         for (int i = 0; i < VSL * LINE; i++) begin s = '{1'b1, 1'b0, 8'h00}; q.push_back(s); end
         for (int i = 0; i < VB * LINE; i++) begin s = '{1'b0, 1'b0, 8'h00}; q.push_back(s); end
         for (int l = 0; l < VA; l++) begin
            for (int b = 0; b < ACT; b++) begin
               s = '{1'b0, 1'b1, pat ? 8'(b ^ l) : mem_arr[l * ACT + b]};
               q.push_back(s);
            end
            for (int b = 0; b < HB; b++) begin s = '{1'b0, 1'b0, 8'h00}; q.push_back(s); end
         end
         for (int i = 0; i < VF * LINE; i++) begin s = '{1'b0, 1'b0, 8'h00}; q.push_back(s); end
      end
   endtask

   task automatic run_frames(input int n, input int delay, input bit mid, input bit pat,
                             input bit idle_chk, input int exp_rd);
      slot_t exp_q [$];
      int    lat, exp_lat, cyc, bad, m, idx;
      bit    got;
      continuous = (n > 1);
`ifdef TEST_PATTERN_EN
      pattern_sel = pat;
`endif
      repeat (delay) @(posedge clk);
      @(posedge clk); #1;
      obs_q.delete(); rd_q.delete();
      done_cnt = 0; vs_rise = 0; hs_rise = 0;
      exp_lat = PXCLK ? 1 : 2;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!VSYNC && lat < 4) begin @(posedge clk); #1; lat++; end
      chk("vsync_latency", 64'(lat), 64'(exp_lat));
      chk("busy_at_vsync", 64'(busy), 64'(1));
      cyc = 0; got = 1'b0;
      while (!got && cyc < n * FRAME_CLKS + 20) begin
         @(posedge clk); #1;
         cyc++;
         if (vs_rise >= n) continuous = 1'b0;
         start = mid && (cyc == 40);
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk("done_seen", 64'(got), 64'(1));
      @(negedge clk); #1;
      chk("done_count", 64'(done_cnt), 64'(1));
      chk("vsync_frames", 64'(vs_rise), 64'(n));

      build_exp(n, pat, exp_q);
      chk("slot_count", 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      bad = -1;
      for (int i = 0; i < m; i++) if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
      if (m > 0) begin
         idx = (bad >= 0) ? bad : m - 1;
         chk($sformatf("slot[%0d] vs/hs/d", idx), 64'(obs_q[idx]), 64'(exp_q[idx]));
      end

      chk("rd_count", 64'(rd_q.size()), 64'(exp_rd));
      if (!pat) begin
         m = (rd_q.size() < n * NBYTES) ? rd_q.size() : n * NBYTES;
         bad = -1;
         for (int i = 0; i < m; i++) if (bad < 0 && rd_q[i] != i % NBYTES) bad = i;
         if (m > 0) begin
            idx = (bad >= 0) ? bad : m - 1;
            chk($sformatf("rd_addr[%0d]", idx), 64'(rd_q[idx]), 64'(idx % NBYTES));
         end
      end

      if (idle_chk) begin
         repeat (6) @(posedge clk); #1;
         chk("ignored_start_stays_idle", 64'(busy), 64'(0));
      end
   endtask

   vec_t vecs [$];

   initial begin
      vec_t v;
      int   cyc;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   cyc;
      reset = 1'b1; start = 1'b0; continuous = 1'b0;
      fill_mem(1'b0);

      vecs.push_back('{1, 0, 1'b0, 1'b0, 1'b0, NBYTES});
      vecs.push_back('{1, 1, 1'b0, 1'b0, 1'b0, NBYTES});
      vecs.push_back('{3, 0, 1'b0, 1'b0, 1'b0, 3 * NBYTES});
      vecs.push_back('{1, 2, 1'b1, 1'b1, 1'b0, NBYTES});
      for (int i = 0; i < 4; i++) begin
         v.n_frames = int'($urandom_range(1, 3));
         v.delay    = int'($urandom_range(0, 3));
         v.rand_mem = 1'b1; v.mid_start = 1'b0; v.pat = 1'b0;
         v.exp_rd   = v.n_frames * NBYTES;
         vecs.push_back(v);
      end
`ifdef TEST_PATTERN_EN
      vecs.push_back('{1, 0, 1'b0, 1'b0, 1'b1, 0});
      vecs.push_back('{2, 1, 1'b1, 1'b0, 1'b1, 0});
`endif

      repeat (2) @(posedge clk); #1;
      chk("reset_outputs", 64'({PXCLK, VSYNC, HSYNC, D, mem_rd, mem_addr, busy, done}), 64'(0));
      @(posedge clk); #1;
      chk("reset_pxclk_held", 64'(PXCLK), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;
      chk("pxclk_runs", 64'(PXCLK), 64'(1));

      foreach (vecs[i]) begin
         v = vecs[i];
         fill_mem(v.rand_mem);
         run_frames(v.n_frames, v.delay, v.mid_start, v.pat, v.mid_start, v.exp_rd);
      end

      // Start while busy is ignored; a start one clock after done launches the next frame
      fill_mem(1'b0);
      run_frames(1, 0, 1'b1, 1'b0, 1'b0, NBYTES);
      run_frames(1, 0, 1'b0, 1'b0, 1'b0, NBYTES);

      // Reset in the middle of the second active line aborts, then a fresh frame starts at 0
      continuous = 1'b0;
      @(posedge clk); #1;
      hs_rise = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (hs_rise < 2 && cyc < 2 * FRAME_CLKS) begin @(posedge clk); #1; cyc++; end
      chk("reached_line2", 64'(hs_rise), 64'(2));
      repeat (3) @(posedge clk); #1;
      chk("busy_before_abort", 64'({busy, HSYNC}), 64'(2'b11));
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort_outputs", 64'({PXCLK, VSYNC, HSYNC, D, mem_rd, mem_addr, busy, done}), 64'(0));
      reset = 1'b0;
      run_frames(1, 1, 1'b0, 1'b0, 1'b0, NBYTES);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
